datapath_loader: RTL and testbench

Hardware replacement for the file-based preload/run/stop sequence around `DATAPATH`. It accepts a valid/ready word stream and writes the register bank and then the instruction memory through write ports. It then enables the datapath for a fixed number of cycles and captures the datapath result (`pru`). It also compares that result against a golden word taken from the end of the stream, so one block supports self-checking runs of any register-bank depth, instruction depth, width and run length.

---
 rtl/datapath_loader.sv | 107 ++++++++++
 tb/tb_datapath_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/datapath_loader.sv
// datapath_loader: streams register/instruction preload into a datapath, runs it for a fixed cycle count, then captures and checks its result.
module datapath_loader #(
  parameter int DATA_W = 32,
  parameter int REG_DEPTH = 32,
  parameter int INST_DEPTH = 64,
  parameter int RUN_CYCLES = 10,
  localparam int RA_W = $clog2(REG_DEPTH),
  localparam int IA_W = $clog2(INST_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              reg_we,
  output logic [RA_W-1:0]   reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              inst_we,
  output logic [IA_W-1:0]   inst_addr,
  output logic [DATA_W-1:0] inst_wdata,
  output logic              dp_run,
  input  logic [DATA_W-1:0] dp_result,
  output logic [DATA_W-1:0] result,
  output logic              match,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, LOAD_REG, LOAD_INST, LOAD_GOLD, RUN, CAPTURE, DONE} state_t;
  localparam int MD = REG_DEPTH > INST_DEPTH ? REG_DEPTH : INST_DEPTH;
  localparam int MX = MD > RUN_CYCLES ? MD : RUN_CYCLES;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] golden;
  logic xfer;
  assign in_ready = state == LOAD_REG || state == LOAD_INST || state == LOAD_GOLD;
  assign xfer = in_valid && in_ready;
  assign dp_run = state == RUN;
  assign done = state == DONE;
  assign busy = !(state == IDLE || state == DONE);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = LOAD_REG;
        cnt_n = '0;
      end
      LOAD_REG: if (xfer) begin
        state_n = cnt == CW'(REG_DEPTH - 1) ? LOAD_INST : LOAD_REG;
        cnt_n = cnt == CW'(REG_DEPTH - 1) ? '0 : cnt + 1'b1;
      end
      LOAD_INST: if (xfer) begin
        state_n = cnt == CW'(INST_DEPTH - 1) ? LOAD_GOLD : LOAD_INST;
        cnt_n = cnt == CW'(INST_DEPTH - 1) ? '0 : cnt + 1'b1;
      end
      LOAD_GOLD: if (xfer) begin
        state_n = RUN;
        cnt_n = '0;
      end
      RUN: begin
        state_n = cnt == CW'(RUN_CYCLES - 1) ? CAPTURE : RUN;
        cnt_n = cnt == CW'(RUN_CYCLES - 1) ? '0 : cnt + 1'b1;
      end
      CAPTURE: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      golden <= '0;
      reg_we <= 1'b0;
      reg_addr <= '0;
      reg_wdata <= '0;
      inst_we <= 1'b0;
      inst_addr <= '0;
      inst_wdata <= '0;
      result <= '0;
      match <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      reg_we <= xfer && state == LOAD_REG;
      inst_we <= xfer && state == LOAD_INST;
      if (xfer && state == LOAD_REG) begin
        reg_addr <= cnt[RA_W-1:0];
        reg_wdata <= in_data;
      end
      if (xfer && state == LOAD_INST) begin
        inst_addr <= cnt[IA_W-1:0];
        inst_wdata <= in_data;
      end
      if (xfer && state == LOAD_GOLD) golden <= in_data;
      if (start && !busy) begin
        result <= '0;
        match <= 1'b0;
      end
      if (state == CAPTURE) begin
        result <= dp_result;
        match <= dp_result == golden;
      end
    end
  end
endmodule

// File: tb/tb_datapath_loader.sv
// tb_datapath_loader: table-driven and randomized runs of datapath_loader against a stream-level model.
module tb_datapath_loader;
  localparam int RD = 4, ID = 4, RC = 3, NW = RD + ID + 1;
  localparam int BRD = 32, BID = 64, BRC = 10, BNW = BRD + BID + 1;
  logic clk = 0, rst = 1, start_a = 0, start_b = 0, in_valid = 0;
  logic [31:0] in_data = 0, dp_result = 0;
  logic a_ready, a_reg_we, a_inst_we, a_run, a_match, a_busy, a_done;
  logic [1:0] a_reg_addr, a_inst_addr;
  logic [31:0] a_reg_wdata, a_inst_wdata, a_result;
  logic b_ready, b_reg_we, b_inst_we, b_run, b_match, b_busy, b_done;
  logic [4:0] b_reg_addr;
  logic [5:0] b_inst_addr;
  logic [31:0] b_reg_wdata, b_inst_wdata, b_result;
  int checks = 0, errors = 0;
  typedef struct {int mode; logic [31:0] gold; logic [31:0] dpr; int exp_len; int rst_at; bit poke;} vec_t;
  vec_t vt[5];

  datapath_loader #(.DATA_W(32), .REG_DEPTH(RD), .INST_DEPTH(ID), .RUN_CYCLES(RC)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_data(in_data), .in_ready(a_ready),
    .reg_we(a_reg_we), .reg_addr(a_reg_addr), .reg_wdata(a_reg_wdata),
    .inst_we(a_inst_we), .inst_addr(a_inst_addr), .inst_wdata(a_inst_wdata),
    .dp_run(a_run), .dp_result(dp_result), .result(a_result), .match(a_match), .busy(a_busy), .done(a_done));

  datapath_loader dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_data(in_data), .in_ready(b_ready),
    .reg_we(b_reg_we), .reg_addr(b_reg_addr), .reg_wdata(b_reg_wdata),
    .inst_we(b_inst_we), .inst_addr(b_inst_addr), .inst_wdata(b_inst_wdata),
    .dp_run(b_run), .dp_result(dp_result), .result(b_result), .match(b_match), .busy(b_busy), .done(b_done));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_a(input int mode, input logic [31:0] gold, input logic [31:0] dpr,
                       input int exp_len, input int rst_at, input bit poke, input bit fixed);
    logic [31:0] w [NW];
    int idx, cyc, g, dcyc, pi;
    bit px, er, ed;
    for (int i = 0; i < NW; i++)
      w[i] = !fixed ? $urandom : i < RD ? 32'(10 + i) : 32'('hA0 + i - RD);
    w[NW-1] = gold;
    start_a = 1;
    in_valid = mode == 2 ? 1'($urandom % 2) : 1'b0;
    dp_result = ~dpr;
    step();
    start_a = 0;
    chk("start_clears_done", a_done, 0);
    chk("start_clears_match", a_match, 0);
    chk("start_clears_result", a_result, 0);
    chk("busy_after_start", a_busy, 1);
    idx = 0; cyc = 1; g = -1; dcyc = -1; px = 0; pi = 0;
    while (dcyc < 0 && cyc < 400) begin
      er = idx < NW;
      ed = g >= 0 && cyc >= g + RC + 2;
      chk("in_ready", a_ready, er);
      chk("reg_we", a_reg_we, px && pi < RD);
      if (px && pi < RD) begin
        chk("reg_addr", a_reg_addr, pi);
        chk("reg_wdata", a_reg_wdata, w[pi]);
      end
      chk("inst_we", a_inst_we, px && pi >= RD && pi < RD + ID);
      if (px && pi >= RD && pi < RD + ID) begin
        chk("inst_addr", a_inst_addr, pi - RD);
        chk("inst_wdata", a_inst_wdata, w[pi]);
      end
      chk("dp_run", a_run, g >= 0 && cyc > g && cyc <= g + RC);
      chk("done", a_done, ed);
      chk("busy", a_busy, !ed);
      if (ed) dcyc = cyc;
      else if (rst_at > 0 && g >= 0 && cyc == g + rst_at) begin
        rst = 1;
        step();
        rst = 0;
        in_valid = 0;
        chk("rst_dp_run", a_run, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_result", a_result, 0);
        chk("rst_done", a_done, 0);
        chk("rst_in_ready", a_ready, 0);
        chk("rst_strobes", {a_reg_we, a_inst_we}, 0);
        return;
      end else begin
        in_valid = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : ($urandom % 3 != 0);
        in_data = idx < NW ? w[idx] : $urandom;
        dp_result = g >= 0 && cyc == g + RC + 1 ? dpr : ~dpr;
        start_a = poke && (idx == RD + 1 || (g >= 0 && cyc == g + 2));
        px = in_valid && er;
        pi = idx;
        if (px) begin
          if (idx == NW - 1) g = cyc;
          idx++;
        end
        step();
        cyc++;
      end
    end
    start_a = 0;
    if (dcyc < 0) chk("done_timeout", 0, 1);
    if (exp_len > 0) chk("run_length", dcyc, exp_len);
    chk("result", a_result, dpr);
    chk("match", a_match, dpr == gold);
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("done_in_ready", a_ready, 0);
      chk("done_strobes", {a_reg_we, a_inst_we, a_run}, 0);
      chk("done_hold", a_done, 1);
      chk("result_hold", a_result, dpr);
      chk("match_hold", a_match, dpr == gold);
    end
    in_valid = 0;
  endtask

  task automatic run_b();
    logic [31:0] w [BNW];
    int idx, cyc, g, dcyc, nr, ni, nrun;
    for (int i = 0; i < BNW; i++) w[i] = $urandom;
    start_b = 1;
    step();
    start_b = 0;
    idx = 0; cyc = 1; g = -1; dcyc = -1; nr = 0; ni = 0; nrun = 0;
    while (dcyc < 0 && cyc < 400) begin
      if (b_reg_we) begin
        chk("b_reg_addr", b_reg_addr, nr);
        chk("b_reg_wdata", b_reg_wdata, w[nr]);
        nr++;
      end
      if (b_inst_we) begin
        chk("b_inst_addr", b_inst_addr, ni);
        chk("b_inst_wdata", b_inst_wdata, w[BRD + ni]);
        ni++;
      end
      if (b_run) nrun++;
      if (b_done) dcyc = cyc;
      else begin
        in_valid = 1;
        in_data = idx < BNW ? w[idx] : $urandom;
        dp_result = g >= 0 && cyc == g + BRC + 1 ? w[BNW-1] : ~w[BNW-1];
        if (idx < BNW && b_ready) begin
          if (idx == BNW - 1) g = cyc;
          idx++;
        end
        step();
        cyc++;
      end
    end
    in_valid = 0;
    chk("b_done_cycle", dcyc, BNW + BRC + 2);
    chk("b_reg_count", nr, BRD);
    chk("b_inst_count", ni, BID);
    chk("b_run_cycles", nrun, BRC);
    chk("b_result", b_result, w[BNW-1]);
    chk("b_match", b_match, 1);
  endtask

  initial begin
    vt[0] = '{0, 32'd5, 32'd5, 14, 0, 0};
    vt[1] = '{0, 32'd5, 32'd6, 14, 0, 0};
    vt[2] = '{1, 32'd5, 32'd5, 23, 0, 0};
    vt[3] = '{0, 32'd5, 32'd6, 14, 0, 1};
    vt[4] = '{0, 32'd5, 32'd5, 0, 2, 0};
    step();
    step();
    rst = 0;
    chk("reset_state", {a_ready, a_reg_we, a_inst_we, a_run, a_match, a_busy, a_done}, 0);
    chk("reset_addr", {a_reg_addr, a_inst_addr}, 0);
    chk("reset_wdata", a_reg_wdata | a_inst_wdata, 0);
    chk("reset_result", a_result, 0);
    for (int i = 0; i < 5; i++)
      run_a(vt[i].mode, vt[i].gold, vt[i].dpr, vt[i].exp_len, vt[i].rst_at, vt[i].poke, 1'b1);
    run_a(0, 32'd5, 32'd5, 14, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] gd;
      gd = $urandom;
      run_a(2, gd, ($urandom % 2) ? gd : $urandom, 0, 0, 1'b1, 1'b0);
    end
    run_b();
    run_b();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
